// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// Latency and backpressure are defined by the arbiter; this bundle holds no state.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic [3:0] hold_cnt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  hold_cnt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output hold_cnt
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a per-grant hold limit; grant follows req by 1 cycle.
// There is no backpressure: requesters hold req until granted, and handover has no idle gap.
module rr_arbiter4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter4_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic       vld_q, vld_d;
    logic [3:0] cnt_q, cnt_d;
    logic       release_now;

    // First set bit of r scanning base, base+1, ... (mod 4).
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] c;
        pick = base;
        for (int k = 3; k >= 0; k--) begin
            c = base + 2'(k);
            if (r[c]) pick = c;
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            vld_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        vld_d       = vld_q;
        cnt_d       = cnt_q;
        release_now = !bus.req[idx_q] || (cnt_q == HOLD_LIM);
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    idx_d   = pick(bus.req, ptr_q);
                    vld_d   = 1'b1;
                    cnt_d   = 4'd1;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    // A released owner drops to lowest priority, even when re-granted.
                    ptr_d = idx_q + 2'd1;
                    if (|bus.req) begin
                        idx_d = pick(bus.req, idx_q + 2'd1);
                        cnt_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        cnt_d   = 4'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt       = vld_q ? (4'b0001 << idx_q) : 4'b0000;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = vld_q;
    assign bus.hold_cnt  = cnt_q;

endmodule
